// File: rtl/bcd_to_bin_seq_if.sv
// Valid/ready bundle for the sequential BCD-to-binary converter.
// The master drives words in and takes results out; the converter is the slave.
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic [4*DIGITS-1:0] bcd_in;
    logic                in_valid;
    logic                in_ready;
    logic [BIN_W-1:0]    bin_out;
    logic                err;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output bcd_in, in_valid, out_ready,
        input  in_ready, bin_out, err, out_valid
    );

    modport slave (
        input  bcd_in, in_valid, out_ready,
        output in_ready, bin_out, err, out_valid
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Multi-digit BCD to binary converter: one digit per clock, MS digit first,
// acc = acc*10 + digit. Any nibble above 9 forces a zero result with err set.
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_to_bin_seq_if.slave bus
);
    localparam int ACC_W = BIN_W + 4;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              state_reg, state_next;
    logic [4*DIGITS-1:0] shift_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic [ACC_W-1:0]    acc_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic                err_flag_reg;
    logic                err_reg;
    logic [BIN_W-1:0]    bin_reg;
    logic [DIGITS-1:0]   nibble_bad;
    logic [3:0]          top_nibble;
    logic                accept;
    logic                last_step;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign nibble_bad[gi] = (bus.bcd_in[4*gi +: 4] > 4'd9);
        end
    endgenerate

    assign top_nibble = shift_reg[4*DIGITS-1 -: 4];
    // acc*10 as (acc<<3)+(acc<<1); the 4 spare bits keep the sum from wrapping.
    assign acc_next   = (acc_reg << 3) + (acc_reg << 1) + {{BIN_W{1'b0}}, top_nibble};
    assign accept     = (state_reg == IDLE) && bus.in_valid;
    assign last_step  = (state_reg == CONV) && (cnt_reg == LAST);

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.bin_out   = bin_reg;
    assign bus.err       = err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid)  state_next = CONV;
            CONV:    if (last_step)     state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg    <= '0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            err_flag_reg <= 1'b0;
            err_reg      <= 1'b0;
            bin_reg      <= '0;
        end else if (accept) begin
            shift_reg    <= bus.bcd_in;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            err_flag_reg <= |nibble_bad;
        end else if (state_reg == CONV) begin
            acc_reg   <= acc_next;
            shift_reg <= shift_reg << 4;
            cnt_reg   <= cnt_reg + CNT_W'(1);
            if (last_step) begin
                bin_reg <= err_flag_reg ? '0 : acc_next[BIN_W-1:0];
                err_reg <= err_flag_reg;
            end
        end
    end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: expected results queued at accept, compared at
// the output handshake; latency, throughput, backpressure and reset checked.
module tb_bcd_to_bin_seq;
    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   prev_accept = 0;
    int   chk_cnt = 0;
    int   err_cnt = 0;
    logic ov_prev = 1'b0;
    exp_t sb[$];

    bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint want);
        chk_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference decode: positional weights, invalid nibble -> (0, err).
    function automatic exp_t model(input logic [4*DIGITS-1:0] w);
        exp_t r;
        int   v = 0;
        int   wt = 1;
        logic bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            logic [3:0] n;
            n = w[4*i +: 4];
            if (n > 4'd9) bad = 1'b1;
            v = v + int'(n) * wt;
            wt = wt * 10;
        end
        r.bin = bad ? '0 : BIN_W'(v);
        r.err = bad;
        return r;
    endfunction

    task automatic send(input logic [4*DIGITS-1:0] w);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", longint'(bus.in_ready), 1);
        bus.bcd_in   = w;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        prev_accept  = accept_cyc;
        accept_cyc   = cyc;
        sb.push_back(model(w));
        $display("accept bcd=%h at cycle %0d", w, accept_cyc);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_wait", longint'(bus.out_valid), 1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && !ov_prev)
                check("latency", cyc - accept_cyc, DIGITS);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("result bin=%0d err=%0d (want %0d/%0d)", bus.bin_out, bus.err, e.bin, e.err);
                    check("bin_out", longint'(bus.bin_out), longint'(e.bin));
                    check("err", longint'(bus.err), longint'(e.err));
                end
            end
        end
        ov_prev = bus.out_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.bcd_in    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_in_ready", longint'(bus.in_ready), 1);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_bin_out", longint'(bus.bin_out), 0);
        check("rst_err", longint'(bus.err), 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        send(16'h0000);
        wait_valid();

        send(16'h1234);
        for (int i = 0; i < 5; i++) begin
            check("in_ready_busy", longint'(bus.in_ready), 0);
            @(posedge clk); #1;
        end
        check("in_ready_back", longint'(bus.in_ready), 1);

        send(16'h9999);
        send(16'h0001);
        check("throughput_1", accept_cyc - prev_accept, DIGITS + 2);
        send(16'h0500);
        check("throughput_2", accept_cyc - prev_accept, DIGITS + 2);
        wait_valid();

        send(16'h12A4);
        send(16'h0042);
        wait_valid();
        @(posedge clk); #1;

        // Backpressure: result must hold while stray in_valid pulses are ignored.
        bus.out_ready = 1'b0;
        send(16'h0777);
        wait_valid();
        for (int i = 0; i < 7; i++) begin
            bus.bcd_in   = 16'h0001;
            bus.in_valid = (i % 2 == 0);
            check("stall_valid", longint'(bus.out_valid), 1);
            check("stall_bin", longint'(bus.bin_out), 777);
            check("stall_in_ready", longint'(bus.in_ready), 0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_stall_in_ready", longint'(bus.in_ready), 1);
        check("post_stall_bin_hold", longint'(bus.bin_out), 777);

        // Reset during the second conversion cycle.
        send(16'h4321);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", longint'(bus.out_valid), 0);
        check("midrst_in_ready", longint'(bus.in_ready), 1);
        check("midrst_bin_out", longint'(bus.bin_out), 0);
        sb.delete();
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'h0010);
        wait_valid();

        for (int k = 0; k < 8; k++) begin
            logic [15:0] w;
            for (int d = 0; d < DIGITS; d++)
                w[4*d +: 4] = 4'($urandom_range(0, 9));
            if (k % 3 == 2)
                w[4*(k % DIGITS) +: 4] = 4'($urandom_range(10, 15));
            send(w);
        end
        wait_valid();
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential multi-digit BCD-to-binary converter. It is the reverse-direction companion to the team's binary-to-BCD code converters. It accepts a packed DIGITS-wide BCD word over a valid/ready handshake and produces the binary value. It uses a multiply-by-10-and-accumulate datapath, processing one digit per clock, most significant digit first. It flags any non-decimal digit (1010–1111) as an error.

Parameters:
DIGITS, 4, number of BCD digits in the input word (1..8)
BIN_W, 14, binary output width; must be >= ceil(log2(10^DIGITS)); 14 covers 9999

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
bcd_in  input  4*DIGITS  packed BCD; digit DIGITS-1 in MS nibble
in_valid  input  1  bcd_in valid
in_ready  output  1  converter can accept a word
bin_out  output  BIN_W  converted binary value
err  output  1  at least one input nibble > 9; qualified by out_valid
out_valid  output  1  bin_out/err valid
out_ready  input  1  downstream accepts result

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, bin_out=0, err=0, accumulator=0, digit counter=0, shift register=0.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at a rising edge: capture bcd_in into the digit shift register, clear the accumulator, clear the counter.
  - err_flag <= OR over all nibbles of (nibble > 9), evaluated on the captured bcd_in.
  - Go to CONV.
- CONV:
  - in_ready=0. Each cycle: acc <= (acc<<3) + (acc<<1) + top_nibble, truncated to BIN_W.
  - Shift register shifts left 4; counter increments.
  - On the step where counter = DIGITS-1: go to DONE.
  - Load bin_out = err_flag ? 0 : final acc; load err = err_flag; set out_valid=1.
- DONE:
  - out_valid=1; bin_out and err held stable.
  - On out_valid&out_ready: clear out_valid, return to IDLE.
  - bin_out/err keep their last value after the handshake.
- Timing:
  - Latency: handshake accepted at edge k → out_valid high after edge k+DIGITS.
  - No accept in the same cycle as output handshake; in_ready rises the cycle after.
  - Throughput: one word per DIGITS+2 cycles at best.
- in_valid while not in IDLE: ignored; bcd_in is not sampled.
- Invalid digit: conversion still runs its full DIGITS cycles, so latency is identical. Result is forced to bin_out=0, err=1.
- Arithmetic: unsigned. Accumulator is BIN_W+4 bits internally; no overflow is possible when BIN_W meets the width rule.
- Reset asserted mid-conversion or in DONE: immediately returns to reset values; the partial result is discarded and out_valid drops asynchronously.
- out_ready held low indefinitely: stays in DONE; outputs stable; in_ready stays 0.
- out_ready high before out_valid: no effect.

Test Plan:
- Reset, then bcd_in=16'h0000 with in_valid pulse → out_valid high exactly 4 cycles after accept; bin_out=0, err=0.
- bcd_in=16'h1234 → bin_out=14'd1234 (0x04D2), err=0. in_ready low for cycles 1..5 after accept.
- bcd_in=16'h9999 → bin_out=14'd9999 (0x270F), err=0. Then 16'h0001 → 1 and 16'h0500 → 500 back-to-back with out_ready tied 1; each accept exactly 6 cycles apart.
- bcd_in=16'h12A4 → after 4 cycles out_valid=1, err=1, bin_out=0. Next word 16'h0042 → 42, err=0 (err_flag does not persist).
- Backpressure: 16'h0777 converted with out_ready=0 for 7 cycles. bin_out=777 and out_valid held stable throughout; in_valid pulses of 16'h0001 during the stall are ignored. out_ready=1 → IDLE, in_ready=1 next cycle.
- Assert rst_n=0 during the 2nd CONV cycle of 16'h4321 → out_valid=0, in_ready=1, bin_out=0 immediately. After release, 16'h0010 → 10.
